// File: rtl/dino_pkg.sv
// Shared types and widths for the dino player slice.
// State encoding, datapath widths and obstacle position width.
package dino_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_AIR  = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  localparam int HEIGHT_W = 8;
  localparam int VEL_W    = 6;
  localparam int SCORE_W  = 16;
  localparam int POS_TOP  = 10;

  function automatic int pos_w(input int conv);
    return POS_TOP - conv;
  endfunction

endpackage

// File: rtl/dino_player_if.sv
// Game-side bundle between input source, player and renderer.
// master drives tick/button/obstacles, slave is the player.
interface dino_player_if
  import dino_pkg::*;
#(
  parameter int CONV = 0
);

  logic                game_tick;
  logic                button_up;
  logic [9:CONV]       obstacle1_pos;
  logic [9:CONV]       obstacle2_pos;
  logic [HEIGHT_W-1:0] player_height;
  logic                airborne;
  logic                crash;
  logic [SCORE_W-1:0]  score;

  modport master (
    output game_tick,
    output button_up,
    output obstacle1_pos,
    output obstacle2_pos,
    input  player_height,
    input  airborne,
    input  crash,
    input  score
  );

  modport slave (
    input  game_tick,
    input  button_up,
    input  obstacle1_pos,
    input  obstacle2_pos,
    output player_height,
    output airborne,
    output crash,
    output score
  );

endinterface

// File: rtl/dino_jump_physics.sv
// Vertical jump integrator: height/velocity with fixed gravity.
// o_landed flags that the next step would reach the ground.
module dino_jump_physics
  import dino_pkg::*;
#(
  parameter int JUMP_V = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_launch,
  input  logic                i_freeze,
  input  logic                i_clear,
  output logic [HEIGHT_W-1:0] o_height,
  output logic                o_landed
);

  localparam int SUM_W = HEIGHT_W + 2;

  logic        [HEIGHT_W-1:0] r_height;
  logic signed [VEL_W-1:0]    r_vel;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [SUM_W-1:0]    w_vel_x;

  assign w_vel_x = {{(SUM_W-VEL_W){r_vel[VEL_W-1]}}, r_vel};
  assign w_sum   = $signed({2'b00, r_height}) + w_vel_x;

  // sum <= 0 (signed) means touchdown this step
  assign o_landed = w_sum[SUM_W-1] | (w_sum == '0);
  assign o_height = r_height;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_height <= '0;
      r_vel    <= '0;
    end else if (i_clear) begin
      r_height <= '0;
      r_vel    <= '0;
    end else if (!i_freeze) begin
      if (i_launch) begin
        r_height <= '0;
        r_vel    <= VEL_W'(JUMP_V);
      end else if (i_tick) begin
        if (o_landed) begin
          r_height <= '0;
          r_vel    <= '0;
        end else begin
          r_height <= w_sum[HEIGHT_W-1:0];
          r_vel    <= r_vel - VEL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dino_player.sv
// Player FSM: start/jump/death sequencing, collision and score.
// Everything advances on game_tick except collision and restart.
module dino_player
  import dino_pkg::*;
#(
  parameter int CONV            = 0,
  parameter int PLAYER_OFFSET   = 6,
  parameter int PLAYER_WIDTH    = 4,
  parameter int OBSTACLE_HEIGHT = 10,
  parameter int JUMP_V          = 8
) (
  input logic          clk,
  input logic          rst_n,
  dino_player_if.slave bus
);

  localparam logic [10:0] X_LO = 11'(PLAYER_OFFSET);
  localparam logic [10:0] X_HI =
    11'(PLAYER_OFFSET + PLAYER_WIDTH);
  localparam logic [8:0]  H_OB = 9'(OBSTACLE_HEIGHT);

  state_t              r_state;
  logic                r_btn_q;
  logic [SCORE_W-1:0]  r_score;
  logic                r_airborne;
  logic                r_crash;

  logic                w_rise;
  logic                w_live;
  logic                w_low;
  logic [10:0]         w_o1;
  logic [10:0]         w_o2;
  logic                w_hit1;
  logic                w_hit2;
  logic                w_hit;
  logic                w_launch;
  logic                w_step;
  logic                w_freeze;
  logic                w_clear;
  logic                w_landed;
  logic [HEIGHT_W-1:0] w_height;
  logic [SCORE_W-1:0]  w_score_inc;

  assign w_rise = bus.button_up & ~r_btn_q;
  assign w_live = (r_state == S_RUN) | (r_state == S_AIR);

  // 11-bit compares so offset+width can never wrap
  assign w_o1   = 11'(bus.obstacle1_pos);
  assign w_o2   = 11'(bus.obstacle2_pos);
  assign w_low  = {1'b0, w_height} < H_OB;
  assign w_hit1 = (w_o1 != '0) & (w_o1 >= X_LO) &
                  (w_o1 < X_HI) & w_low;
  assign w_hit2 = (w_o2 != '0) & (w_o2 >= X_LO) &
                  (w_o2 < X_HI) & w_low;
  assign w_hit  = w_live & (w_hit1 | w_hit2);

  assign w_launch = (r_state == S_RUN) & bus.game_tick &
                    bus.button_up;
  assign w_step   = (r_state == S_AIR) & bus.game_tick;
  assign w_freeze = w_hit | ~w_live;
  assign w_clear  = w_rise &
                    ((r_state == S_DEAD) | (r_state == S_IDLE));

  assign w_score_inc = r_score + SCORE_W'(r_score != '1);

  dino_jump_physics #(
    .JUMP_V (JUMP_V)
  ) u_phys (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tick   (w_step),
    .i_launch (w_launch),
    .i_freeze (w_freeze),
    .i_clear  (w_clear),
    .o_height (w_height),
    .o_landed (w_landed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_btn_q    <= 1'b0;
      r_score    <= '0;
      r_airborne <= 1'b0;
      r_crash    <= 1'b0;
    end else begin
      r_btn_q <= bus.button_up;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_RUN;
            r_score <= '0;
          end
        end
        S_RUN: begin
          if (w_hit) begin
            r_state <= S_DEAD;
            r_crash <= 1'b1;
          end else if (bus.game_tick) begin
            r_score <= w_score_inc;
            if (bus.button_up) begin
              r_state    <= S_AIR;
              r_airborne <= 1'b1;
            end
          end
        end
        S_AIR: begin
          if (w_hit) begin
            r_state    <= S_DEAD;
            r_airborne <= 1'b0;
            r_crash    <= 1'b1;
          end else if (bus.game_tick) begin
            r_score <= w_score_inc;
            if (w_landed) begin
              r_state    <= S_RUN;
              r_airborne <= 1'b0;
            end
          end
        end
        S_DEAD: begin
          if (w_rise) begin
            r_state <= S_RUN;
            r_score <= '0;
            r_crash <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.player_height = w_height;
  assign bus.airborne      = r_airborne;
  assign bus.crash         = r_crash;
  assign bus.score         = r_score;

endmodule

// File: tb/tb_dino_player.sv
// Scoreboard bench for dino_player: expected outputs queued
// at stimulus time and popped after each clock.
module tb_dino_player;

  logic clk;
  logic rst_n;

  dino_player_if #(.CONV(0)) bus ();

  dino_player #(
    .CONV            (0),
    .PLAYER_OFFSET   (6),
    .PLAYER_WIDTH    (4),
    .OBSTACLE_HEIGHT (10),
    .JUMP_V          (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   es;
  int   h;
  int   v;
  int   air;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel,
                      input int e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic expect_st(input string tag, input int eh,
                           input int ea, input int ec,
                           input int esc);
    push({tag, ".height"}, 0, eh);
    push({tag, ".airborne"}, 1, ea);
    push({tag, ".crash"}, 2, ec);
    push({tag, ".score"}, 3, esc);
  endtask

  task automatic drain();
    exp_t x;
    int   obs;
    while (q.size() > 0) begin
      x = q.pop_front();
      case (x.sel)
        0:       obs = int'(bus.player_height);
        1:       obs = int'(bus.airborne);
        2:       obs = int'(bus.crash);
        default: obs = int'(bus.score);
      endcase
      chk(x.tag, obs, x.exp);
    end
  endtask

  task automatic step(input bit tk);
    bus.game_tick = tk;
    @(posedge clk);
    #1;
    bus.game_tick = 1'b0;
  endtask

  task automatic model_tick();
    if (h + v <= 0) begin
      h   = 0;
      v   = 0;
      air = 0;
    end else begin
      h = h + v;
      v = v - 1;
    end
  endtask

  task automatic restart();
    bus.button_up = 1'b0;
    step(0);
    bus.button_up = 1'b1;
    step(0);
    bus.button_up = 1'b0;
    es = 0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.game_tick     = 1'b0;
    bus.button_up     = 1'b0;
    bus.obstacle1_pos = '0;
    bus.obstacle2_pos = '0;
    #3;
    expect_st("reset", 0, 0, 0, 0);
    drain();

    // button activity under reset must not start a run
    @(posedge clk);
    #1;
    bus.button_up = 1'b1;
    step(1);
    bus.button_up = 1'b0;
    step(1);
    expect_st("rst_btn", 0, 0, 0, 0);
    drain();

    rst_n = 1'b1;
    step(0);
    restart();
    expect_st("start", 0, 0, 0, 0);
    drain();
    for (int i = 0; i < 3; i++) begin
      step(1);
      es++;
      expect_st("count", 0, 0, 0, es);
      drain();
    end

    // full jump arc
    bus.button_up = 1'b1;
    step(1);
    bus.button_up = 1'b0;
    es++;
    expect_st("launch", 0, 1, 0, es);
    drain();
    h   = 0;
    v   = 8;
    air = 1;
    for (int t = 1; t <= 17; t++) begin
      step(1);
      es++;
      model_tick();
      expect_st($sformatf("arc%0d", t), h, air, 0, es);
      drain();
    end

    // ground hit coincident with tick, button held high
    bus.button_up     = 1'b1;
    bus.obstacle1_pos = 10'd7;
    expect_st("pre_hit", 0, 0, 0, es);
    drain();
    step(1);
    expect_st("hit", 0, 0, 1, es);
    drain();
    for (int i = 0; i < 5; i++) step(1);
    expect_st("dead_hold", 0, 0, 1, es);
    drain();

    // restart wins over a hit that persists in DEAD
    bus.button_up = 1'b0;
    step(0);
    bus.button_up = 1'b1;
    step(0);
    es = 0;
    expect_st("restart_hit", 0, 0, 0, 0);
    drain();
    step(0);
    expect_st("rehit", 0, 0, 1, 0);
    drain();

    bus.obstacle1_pos = '0;
    restart();
    expect_st("restart", 0, 0, 0, 0);
    drain();

    // x boundaries
    bus.obstacle1_pos = 10'd10;
    step(0);
    step(1);
    es++;
    expect_st("edge10", 0, 0, 0, es);
    drain();
    bus.obstacle1_pos = '0;
    bus.obstacle2_pos = '0;
    step(1);
    es++;
    expect_st("pos0", 0, 0, 0, es);
    drain();
    bus.obstacle2_pos = 10'd6;
    step(0);
    expect_st("edge6", 0, 0, 1, es);
    drain();

    // clear obstacle while high, hit it on the way down
    bus.obstacle2_pos = '0;
    restart();
    bus.button_up = 1'b1;
    step(1);
    bus.button_up = 1'b0;
    es++;
    h   = 0;
    v   = 8;
    air = 1;
    for (int t = 1; t <= 16; t++) begin
      step(1);
      es++;
      model_tick();
      expect_st($sformatf("over%0d", t), h, air, 0, es);
      drain();
      if (t == 2) bus.obstacle2_pos = 10'd8;
    end
    step(0);
    expect_st("air_hit", 8, 0, 1, es);
    drain();

    // asynchronous reset mid-jump
    bus.obstacle2_pos = '0;
    restart();
    bus.button_up = 1'b1;
    step(1);
    bus.button_up = 1'b0;
    es++;
    for (int i = 0; i < 3; i++) begin
      step(1);
      es++;
    end
    expect_st("mid_jump", 21, 1, 0, es);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("async_rst", 0, 0, 0, 0);
    drain();
    step(1);
    rst_n = 1'b1;
    step(1);
    expect_st("post_rst", 0, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
